// File: rtl/puf_ro_eval_if.sv
// Control-side bundle between the PUF register slave and the evaluation
// sequencer.
//   start      : one-cycle evaluation request
//   challenge  : 32-bit challenge, taken when start is accepted
//   busy       : evaluation in progress
//   done       : sticky completion flag
//   response   : RESP_BITS response word, bit i from evaluation step i
//   tie_count  : number of steps whose two counts were equal (saturating)
// master = register slave side, slave = sequencer side.
interface puf_ro_eval_if #(
  parameter int RESP_BITS = 32
);
  logic                 start;
  logic [31:0]          challenge;
  logic                 busy;
  logic                 done;
  logic [RESP_BITS-1:0] response;
  logic [7:0]           tie_count;

  modport master (
    output start, challenge,
    input  busy, done, response, tie_count
  );

  modport slave (
    input  start, challenge,
    output busy, done, response, tie_count
  );
endinterface

// File: rtl/puf_ro_eval_ctrl.sv
// Ring-oscillator PUF evaluation sequencer.
// Expands the challenge through a 32-bit LFSR into a sequence of oscillator
// pair selections; for each pair it lets the bank settle, counts rising edges
// of both selected oscillators over a fixed window and records which was
// faster as one response bit.
// Ports:
//   ACLK, ARESET         : clock, synchronous active-high reset
//   ctrl (slave modport) : start/challenge in, busy/done/response/tie_count out
//   ro_en                : oscillator bank enable, high for the whole evaluation
//   ro_sel_a, ro_sel_b   : selected oscillator indices
//   ro_a, ro_b           : selected oscillator outputs, already in ACLK domain
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for start; response/tie_count/done hold
// ST_SETTLE  | bank enabled, selection stable, SETTLE cycles before counting
// ST_COUNT   | counting rising edges of ro_a/ro_b for WINDOW cycles
// ST_COMPARE | one cycle: record bit, step LFSR, next pair or finish
module puf_ro_eval_ctrl #(
  parameter int N_RO      = 16,
  parameter int RESP_BITS = 32,
  parameter int WINDOW    = 1024,
  parameter int SETTLE    = 16,
  parameter int CNT_W     = 16,
  localparam int SELW     = (N_RO <= 4) ? 2 : $clog2(N_RO)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  puf_ro_eval_if.slave      ctrl,
  output logic              ro_en,
  output logic [SELW-1:0]   ro_sel_a,
  output logic [SELW-1:0]   ro_sel_b,
  input  logic              ro_a,
  input  logic              ro_b
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_COUNT   = 2'd2;
  localparam logic [1:0] ST_COMPARE = 2'd3;

  localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IDXW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  logic [1:0]           state;
  logic [31:0]          lfsr;
  logic [TW-1:0]        timer;
  logic [IDXW-1:0]      idx;
  logic [CNT_W-1:0]     cnt_a;
  logic [CNT_W-1:0]     cnt_b;
  logic                 prev_a;
  logic                 prev_b;
  logic                 busy_q;
  logic                 done_q;
  logic [RESP_BITS-1:0] resp_q;
  logic [7:0]           tie_q;

  logic [31:0] seed;
  logic [31:0] lfsr_nxt;

  assign seed     = (ctrl.challenge == 32'h0) ? 32'h1 : ctrl.challenge;
  assign lfsr_nxt = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};

  // Comparing an oscillator against itself is meaningless, so a colliding
  // B index is nudged to its neighbour.
  function automatic logic [2*SELW-1:0] pick(input logic [31:0] l);
    logic [SELW-1:0] a;
    logic [SELW-1:0] b;
    a = l[SELW-1:0];
    b = l[2*SELW-1:SELW];
    if (b == a) b = a ^ SELW'(1);
    return {b, a};
  endfunction

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= ST_IDLE;
      lfsr     <= 32'h1;
      timer    <= '0;
      idx      <= '0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      prev_a   <= 1'b0;
      prev_b   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      resp_q   <= '0;
      tie_q    <= 8'd0;
      ro_en    <= 1'b0;
      ro_sel_a <= '0;
      ro_sel_b <= '0;
    end else begin
      prev_a <= ro_a;
      prev_b <= ro_b;
      case (state)
        ST_IDLE: begin
          if (ctrl.start) begin
            lfsr                 <= seed;
            {ro_sel_b, ro_sel_a} <= pick(seed);
            resp_q               <= '0;
            tie_q                <= 8'd0;
            idx                  <= '0;
            done_q               <= 1'b0;
            busy_q               <= 1'b1;
            ro_en                <= 1'b1;
            timer                <= TW'(SETTLE - 1);
            state                <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (timer == '0) begin
            timer  <= TW'(WINDOW - 1);
            cnt_a  <= '0;
            cnt_b  <= '0;
            // Edge history restarts with the window so a level that was
            // already high counts as one edge.
            prev_a <= 1'b0;
            prev_b <= 1'b0;
            state  <= ST_COUNT;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        ST_COUNT: begin
          if (ro_a && !prev_a && (cnt_a != '1)) cnt_a <= cnt_a + CNT_W'(1);
          if (ro_b && !prev_b && (cnt_b != '1)) cnt_b <= cnt_b + CNT_W'(1);
          if (timer == '0) state <= ST_COMPARE;
          else             timer <= timer - TW'(1);
        end
        ST_COMPARE: begin
          resp_q[idx] <= (cnt_a > cnt_b);
          if ((cnt_a == cnt_b) && (tie_q != 8'hFF)) tie_q <= tie_q + 8'd1;
          lfsr <= lfsr_nxt;
          if (idx == IDXW'(RESP_BITS - 1)) begin
            busy_q <= 1'b0;
            ro_en  <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            idx                  <= idx + IDXW'(1);
            {ro_sel_b, ro_sel_a} <= pick(lfsr_nxt);
            timer                <= TW'(SETTLE - 1);
            state                <= ST_SETTLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ctrl.busy      = busy_q;
  assign ctrl.done      = done_q;
  assign ctrl.response  = resp_q;
  assign ctrl.tie_count = tie_q;

endmodule

// File: tb/tb_puf_ro_eval_ctrl.sv
module tb_puf_ro_eval_ctrl;
  localparam int RB   = 4;
  localparam int WIN  = 8;
  localparam int STL  = 2;
  localparam int NRO  = 16;
  localparam int SELW = 4;
  localparam int STEP = STL + WIN + 1;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic ro_a = 1'b0;
  logic ro_b = 1'b0;
  logic ro_en, ro_en2;
  logic [SELW-1:0] sel_a, sel_b, sel_a2, sel_b2;

  puf_ro_eval_if #(.RESP_BITS(RB)) bus ();
  puf_ro_eval_if #(.RESP_BITS(RB)) bus2 ();

  puf_ro_eval_ctrl #(.N_RO(NRO), .RESP_BITS(RB), .WINDOW(WIN), .SETTLE(STL), .CNT_W(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .ctrl(bus.slave), .ro_en(ro_en),
    .ro_sel_a(sel_a), .ro_sel_b(sel_b), .ro_a(ro_a), .ro_b(ro_b)
  );

  puf_ro_eval_ctrl #(.N_RO(NRO), .RESP_BITS(RB), .WINDOW(WIN), .SETTLE(STL), .CNT_W(2)) dut_sat (
    .ACLK(ACLK), .ARESET(ARESET), .ctrl(bus2.slave), .ro_en(ro_en2),
    .ro_sel_a(sel_a2), .ro_sel_b(sel_b2), .ro_a(ro_a), .ro_b(ro_b)
  );

  always #5 ACLK = ~ACLK;

  int vecs = 0;
  int errs = 0;
  int mode = 0;  // 0 both low, 1 a faster, 2 identical, 3 b faster
  int nxt  = 0;  // index (relative to start edge 0) of the next edge to sample

  // Oscillator driver. Values are set 2 time units after each edge for the
  // next edge. Window sample k (0..7) of every step falls on p==k.
  // fast: toggles every cycle -> 4 rising edges per window.
  // slow: toggles every 2 cycles, pattern 1,0,0,1,1,0,0,1 -> 3 rising edges.
  initial begin : ro_drv
    int p;
    logic fast, slow;
    forever begin
      @(posedge ACLK);
      #2;
      nxt  = nxt + 1;
      p    = (nxt + 8) % 11;
      fast = nxt[0];
      slow = ((p + 3) >> 1) % 2 == 1;
      case (mode)
        1:       begin ro_a = fast; ro_b = slow; end
        2:       begin ro_a = fast; ro_b = fast; end
        3:       begin ro_a = slow; ro_b = fast; end
        default: begin ro_a = 1'b0; ro_b = 1'b0; end
      endcase
    end
  end

  typedef struct {
    logic [31:0]     chal;
    int              md;
    logic [RB-1:0]   exp_resp;
    logic [7:0]      exp_tie;
    logic [SELW-1:0] exp_a;
    logic [SELW-1:0] exp_b;
  } vec_t;

  vec_t tbl[6];

  task automatic tick(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at #1 after an edge; returns at #1 after the accepting edge 0.
  task automatic start_eval(input bit sat, input logic [31:0] chal);
    if (sat) begin bus2.start = 1'b1; bus2.challenge = chal; end
    else     begin bus.start  = 1'b1; bus.challenge  = chal; end
    tick(1);
    nxt = 0;
    bus.start  = 1'b0;
    bus2.start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    mode = v.md;
    start_eval(1'b0, v.chal);
    chk("first_sel_a", sel_a, v.exp_a);
    chk("first_sel_b", sel_b, v.exp_b);
    chk("busy_set", bus.busy, 1);
    chk("ro_en_set", ro_en, 1);
    chk("done_clr", bus.done, 0);
    tick(STEP * RB - 1);
    chk("done_early", bus.done, 0);
    chk("busy_late", bus.busy, 1);
    chk("ro_en_compare", ro_en, 1);
    tick(1);
    chk("done_rise", bus.done, 1);
    chk("busy_drop", bus.busy, 0);
    chk("ro_en_drop", ro_en, 0);
    chk("response", bus.response, v.exp_resp);
    chk("tie_count", bus.tie_count, v.exp_tie);
    tick(3);
    chk("done_sticky", bus.done, 1);
    chk("response_hold", bus.response, v.exp_resp);
  endtask

  initial begin
    tbl[0] = '{32'hDEADBEEF, 1, 4'hF, 8'd0, 4'hF, 4'hE};
    tbl[1] = '{32'h12345678, 2, 4'h0, 8'd4, 4'h8, 4'h7};
    tbl[2] = '{32'h00000000, 1, 4'hF, 8'd0, 4'h1, 4'h0};
    tbl[3] = '{32'h00000011, 2, 4'h0, 8'd4, 4'h1, 4'h0};
    tbl[4] = '{32'hA5A5A5A5, 0, 4'h0, 8'd4, 4'h5, 4'hA};
    tbl[5] = '{32'hFFFFFFFF, 3, 4'h0, 8'd0, 4'hF, 4'hE};

    bus.start = 1'b0;  bus.challenge  = 32'h0;
    bus2.start = 1'b0; bus2.challenge = 32'h0;
    ARESET = 1'b1;
    tick(2);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_response", bus.response, 0);
    chk("rst_tie", bus.tie_count, 0);
    chk("rst_ro_en", ro_en, 0);
    chk("rst_sel_a", sel_a, 0);
    chk("rst_sel_b", sel_b, 0);
    ARESET = 1'b0;
    tick(1);

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Bit ordering: steps 0,1 a faster, steps 2,3 tied.
    mode = 1;
    start_eval(1'b0, 32'hCAFEF00D);
    tick(24);
    mode = 2;
    tick(20);
    chk("order_done", bus.done, 1);
    chk("order_response", bus.response, 4'b0011);
    chk("order_tie", bus.tie_count, 2);

    // Second start while busy is ignored.
    mode = 1;
    start_eval(1'b0, 32'hDEADBEEF);
    tick(9);
    bus.start = 1'b1; bus.challenge = 32'h00000011;
    tick(1);
    bus.start = 1'b0;
    chk("busy_ign_sel_a", sel_a, 4'hF);
    tick(33);
    chk("busy_ign_early", bus.done, 0);
    tick(1);
    chk("busy_ign_done", bus.done, 1);
    chk("busy_ign_response", bus.response, 4'hF);
    chk("busy_ign_tie", bus.tie_count, 0);

    // Reset mid-evaluation, after a previous done.
    mode = 1;
    start_eval(1'b0, 32'h12345678);
    tick(19);
    chk("mid_busy_pre", bus.busy, 1);
    ARESET = 1'b1;
    tick(1);
    ARESET = 1'b0;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ro_en", ro_en, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_response", bus.response, 0);
    chk("mid_rst_sel_a", sel_a, 0);
    tick(2);
    chk("mid_rst_done_stays", bus.done, 0);
    run_vec(tbl[0]);

    // Reset wins over a simultaneous start.
    ARESET = 1'b1;
    bus.start = 1'b1; bus.challenge = 32'hDEADBEEF;
    tick(1);
    bus.start = 1'b0;
    ARESET = 1'b0;
    chk("rst_prio_busy", bus.busy, 0);
    chk("rst_prio_ro_en", ro_en, 0);
    tick(3);
    chk("rst_prio_still_idle", bus.busy, 0);

    // Saturating counters: 4 vs 3 edges both clip to 3 with CNT_W=2.
    mode = 1;
    start_eval(1'b1, 32'hDEADBEEF);
    chk("sat_busy", bus2.busy, 1);
    tick(STEP * RB - 1);
    chk("sat_done_early", bus2.done, 0);
    tick(1);
    chk("sat_done", bus2.done, 1);
    chk("sat_response", bus2.response, 4'h0);
    chk("sat_tie", bus2.tie_count, 4);
    chk("sat_other_idle", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
